instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder; the inverse of the core decoder. Accepts instruction descriptors (format, ALU op, branch op, register indices, immediate) over a valid/ready handshake.
- Each descriptor is checked for legality, packed into a 32-bit instruction word, and written into instruction memory at an auto-incrementing byte address.
- Used by the test harness and boot loader to program imem without an external assembler. Encodings must round-trip exactly through the core decoder.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- DEPTH, 1024, number of 32-bit words writable before full.
- CNT_W, $clog2(DEPTH+1), width of instr_count.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- prog_clr  in  1  single-cycle pulse; restarts programming at BASE_ADDR.
- enc_valid  in  1  descriptor valid.
- enc_ready  out  1  encoder can accept a descriptor.
- enc_fmt  in  3  t_enc_fmt: ENC_R, ENC_I, ENC_LOAD, ENC_STORE, ENC_BRANCH.
- enc_alu_op  in  t_alu_op  ALU op; used for ENC_R and ENC_I.
- enc_br_op  in  t_branch_cond_op  branch condition; used for ENC_BRANCH.
- enc_mem_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- enc_mem_unsigned  in  1  unsigned load (LBU/LHU).
- enc_rd, enc_rs1, enc_rs2  in  5 each  register indices.
- enc_imm  in  32  signed immediate (byte offset for branches).
- wr_valid  out  1  imem write request.
- wr_ready  in  1  imem accepts the write.
- wr_addr  out  32  byte address, word aligned.
- wr_data  out  32  encoded instruction.
- enc_err  out  1  one-cycle pulse: the accepted descriptor was illegal.
- full  out  1  DEPTH words written.
- instr_count  out  CNT_W  words written since reset or prog_clr.

Behaviour:
- Reset (rst_n low at a clk edge) forces these values, with priority over all other inputs:
  - State IDLE.
  - wr_valid=0, wr_data=0, wr_addr=BASE_ADDR.
  - enc_err=0, full=0, instr_count=0.
- FSM states are IDLE and WRITE.
- enc_ready = (state==IDLE) && !full.
- Accept: enc_valid && enc_ready in cycle N. The descriptor is checked and encoded combinationally, then registered.
  - Legal descriptor: state goes to WRITE. In cycle N+1, wr_valid=1 and wr_data holds the encoded word.
  - Illegal descriptor: enc_err=1 in cycle N+1 only, state stays IDLE, and no write, address change or count change occurs.
- WRITE: wr_valid, wr_addr and wr_data are held stable until wr_ready=1. On that edge:
  - wr_addr += 4 and instr_count += 1.
  - full is set if instr_count reaches DEPTH.
  - State returns to IDLE.
  - Minimum throughput is one instruction per 2 cycles.
- No wrap-around. Once full, enc_ready stays 0 until prog_clr or reset.
- prog_clr in IDLE: wr_addr=BASE_ADDR, instr_count=0, full=0.
- prog_clr in WRITE: the pending write completes first. The clear then takes effect on the IDLE cycle and overrides that cycle's accept (enc_ready is forced 0 in that cycle).
- Field placement: rd [11:7], rs1 [19:15], rs2 [24:20], funct3 [14:12], opcode [6:0].
- ENC_R: opcode 0110011.
  - funct3 follows the alu_op mapping of the decoder.
  - funct7=0100000 for SUB and SRA, 0 otherwise.
  - All ALU ops are legal.
- ENC_I: opcode 0010011.
  - SUB is illegal.
  - Shift ops (SLL/SRL/SRA): imm must be in 0..31. [31:25]=0100000 for SRA, 0 otherwise. [24:20]=imm[4:0].
  - Other ops: imm must be in -2048..2047. [31:20]=imm[11:0].
- ENC_LOAD: opcode 0000011, [31:20]=imm[11:0].
  - funct3 = {unsigned, size}.
  - size=3 is illegal; word with unsigned=1 is illegal.
- ENC_STORE: opcode 0100011, [31:25]=imm[11:5], [11:7]=imm[4:0], funct3={0,size}.
  - size=3 is illegal; enc_mem_unsigned is ignored.
- ENC_BRANCH: opcode 1100011.
  - Immediate uses the same layout as STORE, to match the core decoder's branch immediate.
  - funct3 from br_op: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- Range checks: immediates for ENC_LOAD, ENC_STORE and ENC_BRANCH must be in -2048..2047.
- Any fmt encoding not listed above is illegal.
- enc_rd is ignored for STORE and BRANCH (those bits carry the immediate). enc_rs2 is ignored for I and LOAD.

Decomposition:
- cpu_pkg: add t_enc_fmt; opcode localparams OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH; funct7 constants F7_BASE, F7_ALT. Reuse t_alu_op and t_branch_cond_op.
- Sub-module instr_pack (combinational): descriptor -> {word, illegal}. The top level holds the FSM, address counter and output registers, so the field packing can be unit-tested on its own.

Test Plan:
- ENC_R ADD rd=3 rs1=1 rs2=2, wr_ready=1 -> wr_data=32'h002081B3, wr_addr=0, instr_count=1.
- ENC_R SUB rd=2 rs1=1 rs2=2, then ENC_I ADD rd=5 rs1=0 imm=-1 -> wr_data 32'h40208133 at address 0, then 32'hFFF00293 at address 4.
- ENC_STORE size=2 rs1=1 rs2=2 imm=8 with wr_ready held low 3 cycles -> wr_data=32'h0020A423 stable throughout, enc_ready=0, single write on release.
- ENC_I ADD imm=2048; ENC_I SUB; ENC_LOAD size=2 unsigned=1 -> enc_err pulses one cycle each, no wr_valid, wr_addr unchanged.
- DEPTH=4: write 4 legal descriptors -> full=1, enc_ready=0, 5th enc_valid ignored. prog_clr -> wr_addr=BASE_ADDR, full=0, instr_count=0.
- Deassert rst_n while in WRITE with wr_ready=0 -> next cycle wr_valid=0, state IDLE, counters zero, no write issued.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types plus instruction encoder formats and opcode constants
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_alu_op;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5
  } t_branch_cond_op;

  typedef enum logic [2:0] {
    ENC_R      = 3'd0,
    ENC_I      = 3'd1,
    ENC_LOAD   = 3'd2,
    ENC_STORE  = 3'd3,
    ENC_BRANCH = 3'd4
  } t_enc_fmt;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // {known, funct3}; encodings outside the enum come back as unknown
  function automatic logic [3:0] alu_funct3(input t_alu_op op);
    case (op)
      ALU_ADD, ALU_SUB: return 4'b1_000;
      ALU_SLL:          return 4'b1_001;
      ALU_SLT:          return 4'b1_010;
      ALU_SLTU:         return 4'b1_011;
      ALU_XOR:          return 4'b1_100;
      ALU_SRL, ALU_SRA: return 4'b1_101;
      ALU_OR:           return 4'b1_110;
      ALU_AND:          return 4'b1_111;
      default:          return 4'b0_000;
    endcase
  endfunction

  function automatic logic [3:0] br_funct3(input t_branch_cond_op op);
    case (op)
      BR_BEQ:  return 4'b1_000;
      BR_BNE:  return 4'b1_001;
      BR_BLT:  return 4'b1_100;
      BR_BGE:  return 4'b1_101;
      BR_BLTU: return 4'b1_110;
      BR_BGEU: return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational descriptor to RV32I word packer with legality check
module instr_pack
  import cpu_pkg::*;
(
  input  t_enc_fmt        fmt,
  input  t_alu_op         alu_op,
  input  t_branch_cond_op br_op,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [31:0]     imm,
  output logic [31:0]     word,
  output logic            illegal
);

  logic [3:0] alu_f;
  logic [3:0] br_f;
  logic       imm12_ok;
  logic       shamt_ok;
  logic       is_shift;
  logic       alt;

  // a 12-bit signed immediate fits when bits 31..11 are all copies of the sign
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign shamt_ok = (imm[31:5] == '0);
  assign alu_f    = alu_funct3(alu_op);
  assign br_f     = br_funct3(br_op);
  assign is_shift = (alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA);
  assign alt      = (alu_op == ALU_SUB) || (alu_op == ALU_SRA);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      ENC_R: begin
        word    = {(alt ? F7_ALT : F7_BASE), rs2, rs1, alu_f[2:0], rd, OPC_R};
        illegal = !alu_f[3];
      end
      ENC_I: begin
        if (is_shift) begin
          word    = {((alu_op == ALU_SRA) ? F7_ALT : F7_BASE), imm[4:0], rs1, alu_f[2:0], rd, OPC_I};
          illegal = !shamt_ok;
        end else begin
          word    = {imm[11:0], rs1, alu_f[2:0], rd, OPC_I};
          illegal = !imm12_ok || !alu_f[3] || (alu_op == ALU_SUB);
        end
      end
      ENC_LOAD: begin
        word    = {imm[11:0], rs1, mem_unsigned, mem_size, rd, OPC_LOAD};
        illegal = !imm12_ok || (mem_size == 2'd3) || (mem_unsigned && (mem_size == 2'd2));
      end
      ENC_STORE: begin
        word    = {imm[11:5], rs2, rs1, 1'b0, mem_size, imm[4:0], OPC_STORE};
        illegal = !imm12_ok || (mem_size == 2'd3);
      end
      ENC_BRANCH: begin
        // same split as STORE so the core decoder's branch immediate matches
        word    = {imm[11:5], rs2, rs1, br_f[2:0], imm[4:0], OPC_BRANCH};
        illegal = !imm12_ok || !br_f[3];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - descriptor handshake, imem write FSM and address/count tracking
module instr_encoder
  import cpu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_clr,
  input  logic             enc_valid,
  output logic             enc_ready,
  input  t_enc_fmt         enc_fmt,
  input  t_alu_op          enc_alu_op,
  input  t_branch_cond_op  enc_br_op,
  input  logic [1:0]       enc_mem_size,
  input  logic             enc_mem_unsigned,
  input  logic [4:0]       enc_rd,
  input  logic [4:0]       enc_rs1,
  input  logic [4:0]       enc_rs2,
  input  logic [31:0]      enc_imm,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             enc_err,
  output logic             full,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic {S_IDLE, S_WRITE} t_state;

  t_state      state;
  t_state      state_nxt;
  logic [31:0] word;
  logic        illegal;
  logic        clr_pend;
  logic        clr_now;
  logic        accept;

  instr_pack u_pack (
    .fmt          (enc_fmt),
    .alu_op       (enc_alu_op),
    .br_op        (enc_br_op),
    .mem_size     (enc_mem_size),
    .mem_unsigned (enc_mem_unsigned),
    .rd           (enc_rd),
    .rs1          (enc_rs1),
    .rs2          (enc_rs2),
    .imm          (enc_imm),
    .word         (word),
    .illegal      (illegal)
  );

  // a clear seen during WRITE is parked in clr_pend and applied on the following IDLE cycle
  assign clr_now   = (state == S_IDLE) && (prog_clr || clr_pend);
  assign enc_ready = (state == S_IDLE) && !full && !clr_now;
  assign accept    = enc_valid && enc_ready;
  assign wr_valid  = (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !illegal) state_nxt = S_WRITE;
      S_WRITE: if (wr_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr     <= BASE_ADDR;
      wr_data     <= '0;
      enc_err     <= 1'b0;
      full        <= 1'b0;
      instr_count <= '0;
      clr_pend    <= 1'b0;
    end else begin
      enc_err <= accept && illegal;
      if (accept && !illegal) wr_data <= word;
      if (state == S_WRITE) begin
        if (prog_clr) clr_pend <= 1'b1;
        if (wr_ready) begin
          wr_addr     <= wr_addr + 32'd4;
          instr_count <= instr_count + CNT_W'(1);
          if (instr_count == CNT_W'(DEPTH - 1)) full <= 1'b1;
        end
      end else if (clr_now) begin
        wr_addr     <= BASE_ADDR;
        instr_count <= '0;
        full        <= 1'b0;
        clr_pend    <= 1'b0;
      end
    end
  end

endmodule
